asrv32_dmem_arbiter: RTL and testbench
======================================

// Module: asrv32_dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters: the core memory-access stage (core) and an
//  auxiliary master (aux: debug/DMA). Latches a winner, drives one memory transaction, returns rdata/ack
//  (or error on timeout) to the owner. Sits between the memory-access stage outputs and data memory.
// PARAMETERS
//  ADDR_WIDTH     32   width of all address ports
//  TIMEOUT_CYCLES 255  ACCESS cycles without i_mem_ack before error; 0 disables timeout; counter 8 bits
//  CORE_PRIORITY  0    1: core always wins ties; 0: round-robin between core and aux
// PORTS
//  i_clk          in   1          clock
//  i_rst_n        in   1          asynchronous, active-low reset
//  i_core_req     in   1          core request, held with payload stable until o_core_ack
//  i_core_we      in   1          1 = write, 0 = read
//  i_core_addr    in   ADDR_WIDTH byte address
//  i_core_wdata   in   32         lane-aligned store data
//  i_core_wmask   in   4          byte-enable {b3,b2,b1,b0}
//  o_core_rdata   out  32         read data, valid with o_core_ack
//  o_core_ack     out  1          one-cycle transaction completion
//  o_core_err     out  1          with o_core_ack: transaction timed out
//  o_core_stall   out  1          combinational: i_core_req & ~o_core_ack
//  i_aux_*/o_aux_*  same set as core (req, we, addr, wdata, wmask / rdata, ack, err); no stall output
//  o_mem_req      out  1          memory request, held until i_mem_ack or timeout
//  o_mem_we       out  1          write enable
//  o_mem_addr     out  ADDR_WIDTH address
//  o_mem_wdata    out  32         write data
//  o_mem_wmask    out  4          byte-enable; forced 0 on reads
//  i_mem_ack      in   1          memory completion; i_mem_rdata valid in same cycle
//  i_mem_rdata    in   32         read data
// BEHAVIOUR
//  Reset: all outputs 0 (o_core_stall follows i_core_req), state IDLE, timeout counter 0,
//   last_owner=aux (core wins first tie). Reset mid-transaction abandons it, no ack to owner.
//  FSM IDLE -> ACCESS -> RESP -> IDLE; all outputs except o_core_stall registered.
//  IDLE: if any req, select owner: single requester wins; both -> CORE_PRIORITY=1 core, else the one
//   not equal to last_owner. At the edge: latch owner, drive o_mem_req=1 and o_mem_we/addr/wdata/wmask
//   from owner (wmask=0 if we=0), clear counter, go ACCESS. No req -> stay, outputs idle.
//  ACCESS: memory outputs held stable. i_mem_ack=1 -> capture i_mem_rdata into owner rdata, owner ack=1,
//   err=0, o_mem_req=0, last_owner=owner, go RESP. Else counter+1; when counter reaches TIMEOUT_CYCLES
//   (nonzero) -> owner ack=1, err=1, rdata=0, o_mem_req=0, go RESP. Non-owner requests wait.
//  RESP: exactly one cycle; ack/err/rdata visible; next edge clears ack/err, goes IDLE. rdata holds until
//   the next completion for that requester. Requester drops or replaces req by cycle after ack; IDLE
//   samples only new requests.
//  Latency: req sampled in IDLE cycle N -> o_mem_req at N+1; i_mem_ack in cycle M -> owner ack at M+1;
//   minimum 3 cycles per transaction with zero-wait memory (ack in first ACCESS cycle).
//  i_mem_ack outside ACCESS (late ack after timeout/reset) ignored. Only one owner at a time; o_core_ack and
//   o_aux_ack never both 1. Requester dropping req during ACCESS: transaction still completes and acks.
//  No alignment checking; addr/wmask passed unmodified.
// TESTING
//  1 Core read addr 0x100, mem ack 2 cycles after o_mem_req, rdata 0xDEADBEEF -> o_core_ack one cycle,
//    o_core_rdata=0xDEADBEEF, err=0, o_mem_wmask=0, o_core_stall high until ack.
//  2 Both req continuously, CORE_PRIORITY=0, zero-wait mem -> grants core, aux, core, aux; one ack per 3 cycles.
//  3 Aux write addr 0x204 wmask 4'b0100 wdata 0x00AB0000 in ACCESS, core req arrives -> mem outputs unchanged
//    until aux ack; core granted next IDLE.
//  4 TIMEOUT_CYCLES=4, mem never acks -> after 4 ACCESS cycles o_core_ack=1, o_core_err=1, rdata=0;
//    later i_mem_ack ignored.
//  5 Reset asserted during ACCESS -> all outputs 0 immediately; after release no ack; new core req served.
//  6 CORE_PRIORITY=1, both req continuously -> core granted every transaction, aux never acked.

Source files
------------

// File: rtl/asrv32_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : asrv32_dmem_arbiter
//  Description : Two-master arbiter for the single data-memory port. The core
//                memory-access stage and an auxiliary master (debug/DMA)
//                compete. One winner is latched per transaction. The arbiter
//                drives one memory access and returns rdata/ack (or an error
//                on timeout) to the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module asrv32_dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CORE_PRIORITY  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    // core requester
    input  logic                  i_core_req,
    input  logic                  i_core_we,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [31:0]           i_core_wdata,
    input  logic [3:0]            i_core_wmask,
    output logic [31:0]           o_core_rdata,
    output logic                  o_core_ack,
    output logic                  o_core_err,
    output logic                  o_core_stall,
    // auxiliary requester
    input  logic                  i_aux_req,
    input  logic                  i_aux_we,
    input  logic [ADDR_WIDTH-1:0] i_aux_addr,
    input  logic [31:0]           i_aux_wdata,
    input  logic [3:0]            i_aux_wmask,
    output logic [31:0]           o_aux_rdata,
    output logic                  o_aux_ack,
    output logic                  o_aux_err,
    // data memory
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_wmask,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Owner encoding used by r_owner / r_last_owner
    localparam logic       c_OWN_CORE   = 1'b0;
    localparam logic       c_OWN_AUX    = 1'b1;
    localparam logic       c_CORE_PRI   = (CORE_PRIORITY != 0);
    localparam logic       c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] c_TIMEOUT    = 8'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_owner,        w_owner_nxt;
    logic                  r_last_owner,   w_last_owner_nxt;
    logic [7:0]            r_cnt,          w_cnt_nxt;

    logic                  r_mem_req,      w_mem_req_nxt;
    logic                  r_mem_we,       w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,     w_mem_addr_nxt;
    logic [31:0]           r_mem_wdata,    w_mem_wdata_nxt;
    logic [3:0]            r_mem_wmask,    w_mem_wmask_nxt;

    logic                  r_core_ack,     w_core_ack_nxt;
    logic                  r_core_err,     w_core_err_nxt;
    logic [31:0]           r_core_rdata,   w_core_rdata_nxt;
    logic                  r_aux_ack,      w_aux_ack_nxt;
    logic                  r_aux_err,      w_aux_err_nxt;
    logic [31:0]           r_aux_rdata,    w_aux_rdata_nxt;

    logic                  w_grant_aux;
    logic [7:0]            w_cnt_inc;
    logic                  w_timeout;

    // On a tie the aux wins only in round-robin mode, and only when the core was served last.
    assign w_grant_aux = i_aux_req & (~i_core_req | (~c_CORE_PRI & (r_last_owner == c_OWN_CORE)));

    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_timeout   = c_TIMEOUT_EN & (w_cnt_inc == c_TIMEOUT);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output computation for every registered signal
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_wmask_nxt  = r_mem_wmask;
        w_core_ack_nxt   = 1'b0;
        w_core_err_nxt   = 1'b0;
        w_core_rdata_nxt = r_core_rdata;
        w_aux_ack_nxt    = 1'b0;
        w_aux_err_nxt    = 1'b0;
        w_aux_rdata_nxt  = r_aux_rdata;

        case (r_state)
            ST_IDLE: begin
                if (i_core_req | i_aux_req) begin
                    w_owner_nxt   = w_grant_aux ? c_OWN_AUX : c_OWN_CORE;
                    w_mem_req_nxt = 1'b1;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = ST_ACCESS;
                    if (w_grant_aux) begin
                        w_mem_we_nxt    = i_aux_we;
                        w_mem_addr_nxt  = i_aux_addr;
                        w_mem_wdata_nxt = i_aux_wdata;
                        w_mem_wmask_nxt = i_aux_we ? i_aux_wmask : 4'b0000;
                    end else begin
                        w_mem_we_nxt    = i_core_we;
                        w_mem_addr_nxt  = i_core_addr;
                        w_mem_wdata_nxt = i_core_wdata;
                        w_mem_wmask_nxt = i_core_we ? i_core_wmask : 4'b0000;
                    end
                end
            end

            ST_ACCESS: begin
                if (i_mem_ack || w_timeout) begin
                    // Completion (normal or timed out): release the memory port, answer the owner.
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_wdata_nxt = 32'd0;
                    w_mem_wmask_nxt = 4'b0000;
                    w_state_nxt     = ST_RESP;
                    if (r_owner == c_OWN_AUX) begin
                        w_aux_ack_nxt   = 1'b1;
                        w_aux_err_nxt   = ~i_mem_ack;
                        w_aux_rdata_nxt = i_mem_ack ? i_mem_rdata : 32'd0;
                    end else begin
                        w_core_ack_nxt   = 1'b1;
                        w_core_err_nxt   = ~i_mem_ack;
                        w_core_rdata_nxt = i_mem_ack ? i_mem_rdata : 32'd0;
                    end
                    // Only a successful completion moves the round-robin pointer.
                    if (i_mem_ack) begin
                        w_last_owner_nxt = r_owner;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner      <= c_OWN_CORE;
            r_last_owner <= c_OWN_AUX;
            r_cnt        <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_mem_wmask  <= 4'b0000;
            r_core_ack   <= 1'b0;
            r_core_err   <= 1'b0;
            r_core_rdata <= 32'd0;
            r_aux_ack    <= 1'b0;
            r_aux_err    <= 1'b0;
            r_aux_rdata  <= 32'd0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wmask  <= w_mem_wmask_nxt;
            r_core_ack   <= w_core_ack_nxt;
            r_core_err   <= w_core_err_nxt;
            r_core_rdata <= w_core_rdata_nxt;
            r_aux_ack    <= w_aux_ack_nxt;
            r_aux_err    <= w_aux_err_nxt;
            r_aux_rdata  <= w_aux_rdata_nxt;
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wmask  = r_mem_wmask;
    assign o_core_ack   = r_core_ack;
    assign o_core_err   = r_core_err;
    assign o_core_rdata = r_core_rdata;
    assign o_aux_ack    = r_aux_ack;
    assign o_aux_err    = r_aux_err;
    assign o_aux_rdata  = r_aux_rdata;

    // The core pipeline stalls combinationally until its acknowledge shows up.
    assign o_core_stall = i_core_req & ~r_core_ack;

endmodule
`default_nettype wire

// File: tb/tb_asrv32_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asrv32_dmem_arbiter
//  Description : Self-checking bench for asrv32_dmem_arbiter: directed vector
//                table, reset/timeout sequences, randomized traffic against a
//                transaction-level model, and a fixed-priority instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asrv32_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // main instance: round-robin, timeout after 4 cycles
    logic        core_req, core_we, core_ack, core_err, core_stall;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_wmask;
    logic        aux_req, aux_we, aux_ack, aux_err;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic [3:0]  aux_wmask;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    // priority instance
    logic        p_core_req, p_aux_req, p_mem_ack;
    logic        p_core_ack, p_core_err, p_core_stall, p_aux_ack, p_aux_err;
    logic [31:0] p_core_rdata, p_aux_rdata;
    logic        p_mem_req, p_mem_we;
    logic [31:0] p_mem_addr, p_mem_wdata;
    logic [3:0]  p_mem_wmask;

    asrv32_dmem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .CORE_PRIORITY(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .i_core_wmask(core_wmask),
        .o_core_rdata(core_rdata), .o_core_ack(core_ack), .o_core_err(core_err),
        .o_core_stall(core_stall),
        .i_aux_req(aux_req), .i_aux_we(aux_we), .i_aux_addr(aux_addr),
        .i_aux_wdata(aux_wdata), .i_aux_wmask(aux_wmask),
        .o_aux_rdata(aux_rdata), .o_aux_ack(aux_ack), .o_aux_err(aux_err),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    asrv32_dmem_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0), .CORE_PRIORITY(1)) u_pri (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(p_core_req), .i_core_we(1'b0), .i_core_addr(32'h0000_0010),
        .i_core_wdata(32'd0), .i_core_wmask(4'hF),
        .o_core_rdata(p_core_rdata), .o_core_ack(p_core_ack), .o_core_err(p_core_err),
        .o_core_stall(p_core_stall),
        .i_aux_req(p_aux_req), .i_aux_we(1'b1), .i_aux_addr(32'h0000_0020),
        .i_aux_wdata(32'h1234_5678), .i_aux_wmask(4'h3),
        .o_aux_rdata(p_aux_rdata), .o_aux_ack(p_aux_ack), .o_aux_err(p_aux_err),
        .o_mem_req(p_mem_req), .o_mem_we(p_mem_we), .o_mem_addr(p_mem_addr),
        .o_mem_wdata(p_mem_wdata), .o_mem_wmask(p_mem_wmask),
        .i_mem_ack(p_mem_ack), .i_mem_rdata(32'h5A5A_5A5A)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        creq, areq, mack;
        logic [31:0] mrd;
        logic [4:0]  ectl;    // {mem_req, core_ack, core_err, core_stall, aux_ack}
        logic [31:0] ecrd, eard, eaddr;
        logic [3:0]  ewm;
        logic        ewe;
    } vec_t;

    function automatic vec_t mk(input logic creq, input logic areq, input logic mack,
                                input logic [31:0] mrd, input logic [4:0] ectl,
                                input logic [31:0] ecrd, input logic [31:0] eard,
                                input logic [31:0] eaddr, input logic [3:0] ewm, input logic ewe);
        vec_t v;
        v.creq = creq; v.areq = areq; v.mack = mack; v.mrd = mrd; v.ectl = ectl;
        v.ecrd = ecrd; v.eard = eard; v.eaddr = eaddr; v.ewm = ewm; v.ewe = ewe;
        return v;
    endfunction

    localparam logic [31:0] D  = 32'hDEAD_BEEF;
    localparam logic [31:0] CA = 32'h0000_0100;
    localparam logic [31:0] AA = 32'h0000_0204;
    localparam logic [31:0] R5 = 32'h5555_5555;
    localparam logic [31:0] R2 = 32'h2222_2222;
    localparam logic [31:0] R8 = 32'h8888_8888;
    localparam logic [31:0] RA = 32'hA5A5_A5A5;

    vec_t tbl[28];

    // random-phase model state
    bit          cp, ap, cdrop, adrop, act, own_aux, tmo, last_aux, in_acc, done;
    int          g, e_end, lat, next_free, acks, lat_seen, pc, pa;
    logic [31:0] rd, exp_crd, exp_ard, t_addr, t_wdata;
    logic        t_we;
    logic [3:0]  t_wmask;
    logic        e_mreq, e_cack, e_aack, e_err, e_stall;

    initial begin
        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = CA; core_wdata = 32'hCAFE_F00D; core_wmask = 4'hF;
        aux_req = 1'b0; aux_we = 1'b1; aux_addr = AA; aux_wdata = 32'h00AB_0000; aux_wmask = 4'b0100;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        p_core_req = 1'b0; p_aux_req = 1'b0; p_mem_ack = 1'b0;

        tbl[0]  = mk(1,0,0,32'd0,        5'b00010, 0,  0,  0,  4'h0, 0);
        tbl[1]  = mk(1,0,0,32'd0,        5'b10010, 0,  0,  CA, 4'h0, 0);
        tbl[2]  = mk(1,0,0,32'd0,        5'b10010, 0,  0,  CA, 4'h0, 0);
        tbl[3]  = mk(1,0,1,D,            5'b10010, 0,  0,  CA, 4'h0, 0);
        tbl[4]  = mk(1,0,0,32'd0,        5'b01000, D,  0,  0,  4'h0, 0);
        tbl[5]  = mk(0,0,0,32'd0,        5'b00000, D,  0,  0,  4'h0, 0);
        tbl[6]  = mk(1,1,1,32'h11111111, 5'b00010, D,  0,  0,  4'h0, 0);
        tbl[7]  = mk(1,1,1,R2,           5'b10010, D,  0,  AA, 4'h4, 1);
        tbl[8]  = mk(1,1,1,32'h33333333, 5'b00011, D,  R2, 0,  4'h0, 0);
        tbl[9]  = mk(1,1,1,32'h44444444, 5'b00010, D,  R2, 0,  4'h0, 0);
        tbl[10] = mk(1,1,1,R5,           5'b10010, D,  R2, CA, 4'h0, 0);
        tbl[11] = mk(1,1,1,32'h66666666, 5'b01000, R5, R2, 0,  4'h0, 0);
        tbl[12] = mk(1,1,1,32'h77777777, 5'b00010, R5, R2, 0,  4'h0, 0);
        tbl[13] = mk(1,1,1,R8,           5'b10010, R5, R2, AA, 4'h4, 1);
        tbl[14] = mk(1,0,0,32'd0,        5'b00011, R5, R8, 0,  4'h0, 0);
        tbl[15] = mk(0,1,0,32'd0,        5'b00000, R5, R8, 0,  4'h0, 0);
        tbl[16] = mk(1,1,0,32'd0,        5'b10010, R5, R8, AA, 4'h4, 1);
        tbl[17] = mk(1,1,0,32'd0,        5'b10010, R5, R8, AA, 4'h4, 1);
        tbl[18] = mk(1,1,1,RA,           5'b10010, R5, R8, AA, 4'h4, 1);
        tbl[19] = mk(1,0,0,32'd0,        5'b00011, R5, RA, 0,  4'h0, 0);
        tbl[20] = mk(1,0,0,32'd0,        5'b00010, R5, RA, 0,  4'h0, 0);
        tbl[21] = mk(1,0,0,32'd0,        5'b10010, R5, RA, CA, 4'h0, 0);
        tbl[22] = mk(1,0,0,32'd0,        5'b10010, R5, RA, CA, 4'h0, 0);
        tbl[23] = mk(1,0,0,32'd0,        5'b10010, R5, RA, CA, 4'h0, 0);
        tbl[24] = mk(1,0,0,32'd0,        5'b10010, R5, RA, CA, 4'h0, 0);
        tbl[25] = mk(1,0,1,32'h12345678, 5'b01100, 0,  RA, 0,  4'h0, 0);
        tbl[26] = mk(0,0,1,32'h9ABCDEF0, 5'b00000, 0,  RA, 0,  4'h0, 0);
        tbl[27] = mk(0,0,0,32'd0,        5'b00000, 0,  RA, 0,  4'h0, 0);

        // ---- reset state ----
        #12;
        check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, core_ack, core_err, aux_ack, aux_err},
              128'd0);
        check("reset_rdata", {core_rdata, aux_rdata}, 128'd0);
        check("reset_stall_follows_req", {127'd0, core_stall}, 128'd1);
        core_req = 1'b0;
        #1;
        check("reset_stall_low", {127'd0, core_stall}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---- directed vector table ----
        for (int i = 0; i < 28; i++) begin
            core_req = tbl[i].creq; aux_req = tbl[i].areq;
            mem_ack = tbl[i].mack; mem_rdata = tbl[i].mrd;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), {mem_req, core_ack, core_err, core_stall, aux_ack, aux_err},
                  {tbl[i].ectl, 1'b0});
            check($sformatf("vec%0d_rdata", i), {core_rdata, aux_rdata}, {tbl[i].ecrd, tbl[i].eard});
            if (tbl[i].ectl[4])
                check($sformatf("vec%0d_mem", i), {mem_we, mem_addr, mem_wmask, mem_wdata},
                      {tbl[i].ewe, tbl[i].eaddr, tbl[i].ewm, tbl[i].ewe ? 32'h00AB_0000 : 32'hCAFE_F00D});
            @(posedge clk); #1;
        end

        // ---- reset in the middle of an access ----
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h300; core_wdata = 32'h0102_0304; core_wmask = 4'hF;
        mem_ack = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_access_req", {123'd0, mem_req, mem_wmask}, {123'd0, 1'b1, 4'hF});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, core_ack, core_err, aux_ack, aux_err},
              128'd0);
        check("async_reset_rdata", {core_rdata, aux_rdata}, 128'd0);
        core_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            if (core_ack || aux_ack || mem_req) acks++;
            @(posedge clk); #1;
        end
        check("no_ack_after_reset", acks, 0);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        lat_seen = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_ack && lat_seen < 0) lat_seen = i;
            @(posedge clk); #1;
        end
        check("post_reset_latency", lat_seen, 2);
        check("post_reset_rdata", {core_rdata, 31'd0, core_err}, {32'h0BAD_F00D, 32'd0});
        core_req = 1'b0; mem_ack = 1'b0;

        // ---- randomized traffic against a transaction-level model ----
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cp = 0; ap = 0; cdrop = 0; adrop = 0; act = 0; last_aux = 1; next_free = 0;
        exp_crd = 0; exp_ard = 0; g = 0; e_end = 0; own_aux = 0; tmo = 0; rd = 0;
        t_we = 0; t_addr = 0; t_wdata = 0; t_wmask = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cp && $urandom_range(0, 2) == 0) begin
                cp = 1; core_we = 1'($urandom); core_addr = $urandom; core_wdata = $urandom; core_wmask = 4'($urandom);
            end
            if (!ap && $urandom_range(0, 2) == 0) begin
                ap = 1; aux_we = 1'($urandom); aux_addr = $urandom; aux_wdata = $urandom; aux_wmask = 4'($urandom);
            end
            in_acc = act && n >= g + 1 && n <= g + e_end;
            if (in_acc && !own_aux && $urandom_range(0, 7) == 0) cdrop = 1;
            if (in_acc &&  own_aux && $urandom_range(0, 7) == 0) adrop = 1;
            core_req = cp && !cdrop;
            aux_req  = ap && !adrop;
            if (!act && n >= next_free && (core_req || aux_req)) begin
                own_aux = aux_req && (!core_req || !last_aux);
                act = 1; g = n; lat = $urandom_range(1, 6); tmo = (lat > 4); e_end = tmo ? 4 : lat; rd = $urandom;
                t_we = own_aux ? aux_we : core_we;
                t_addr = own_aux ? aux_addr : core_addr;
                t_wdata = own_aux ? aux_wdata : core_wdata;
                t_wmask = t_we ? (own_aux ? aux_wmask : core_wmask) : 4'h0;
            end
            in_acc = act && n >= g + 1 && n <= g + e_end;
            if (act && !tmo && n == g + e_end) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end else begin
                mem_ack = in_acc ? 1'b0 : ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            @(negedge clk);
            e_mreq = in_acc;
            done = act && n == g + e_end + 1;
            e_cack = done && !own_aux;
            e_aack = done && own_aux;
            e_err = done && tmo;
            e_stall = core_req && !e_cack;
            if (done) begin
                if (own_aux) begin exp_ard = tmo ? 32'd0 : rd; ap = 0; adrop = 0; end
                else         begin exp_crd = tmo ? 32'd0 : rd; cp = 0; cdrop = 0; end
                if (!tmo) last_aux = own_aux;
                act = 0; next_free = n + 1;
            end
            check($sformatf("rand%0d_ctl", n), {mem_req, core_ack, core_err, aux_ack, aux_err, core_stall},
                  {e_mreq, e_cack, e_cack & e_err, e_aack, e_aack & e_err, e_stall});
            check($sformatf("rand%0d_rdata", n), {core_rdata, aux_rdata}, {exp_crd, exp_ard});
            if (e_mreq)
                check($sformatf("rand%0d_mem", n), {mem_we, mem_addr, mem_wdata, mem_wmask},
                      {t_we, t_addr, t_wdata, t_wmask});
            @(posedge clk); #1;
        end
        core_req = 1'b0; aux_req = 1'b0; mem_ack = 1'b0;

        // ---- fixed core priority: core always wins ----
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        p_core_req = 1'b1; p_aux_req = 1'b1; p_mem_ack = 1'b1;
        pc = 0; pa = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (p_core_ack) pc++;
            if (p_aux_ack) pa++;
            @(posedge clk); #1;
        end
        check("pri_core_acks", pc, 10);
        check("pri_aux_acks", pa, 0);
        p_core_req = 1'b0; p_aux_req = 1'b0; p_mem_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
